// File: rtl/usbf_dma_eng.sv
// USB function DMA engine: one 32-bit word per endpoint request,
// moved by a Wishbone master read from SRC then write to DST.
module usbf_dma_eng #(
  parameter int NCH    = 16,
  parameter int TO_CYC = 255
) (
  input  logic           clk_i,
  input  logic           rst,
  input  logic [NCH-1:0] dma_req_i,
  output logic [NCH-1:0] dma_ack_o,
  input  logic           cfg_we_i,
  input  logic [5:0]     cfg_adr_i,
  input  logic [31:0]    cfg_din_i,
  output logic [31:0]    cfg_dout_o,
  output logic [31:0]    m_adr_o,
  output logic [31:0]    m_dat_o,
  input  logic [31:0]    m_dat_i,
  output logic           m_we_o,
  output logic           m_stb_o,
  output logic           m_cyc_o,
  input  logic           m_ack_i,
  input  logic           m_err_i,
  output logic           busy_o,
  output logic           err_o,
  output logic [3:0]     err_ch_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} st_t;

  st_t         st_q, st_d;
  logic [31:0] src_q [NCH];
  logic [31:0] dst_q [NCH];
  logic [2:0]  ctrl_q [NCH];
  logic [3:0]  ch_q, last_q, gnt, idx;
  logic [31:0] sa_q, da_q, dat_q;
  logic [7:0]  to_q;
  logic        err_q;
  logic [3:0]  errch_q;
  logic [NCH-1:0] elig;
  logic        any, ack_ok, abort, phase;
  logic [3:0]  cch;
  logic [1:0]  creg;
  logic        cok;

  assign cch    = cfg_adr_i[5:2];
  assign creg   = cfg_adr_i[1:0];
  assign cok    = ({1'b0, cch} < 5'(NCH));
  assign phase  = (st_q == RD) || (st_q == WR);
  assign ack_ok = m_ack_i && !m_err_i;
  assign abort  = phase && (m_err_i ||
                  (!m_ack_i && to_q == 8'(TO_CYC - 1)));

  // eligible channels: requesting and enabled
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++)
      elig[i] = dma_req_i[i] && ctrl_q[i][0];
  end

  // round-robin search starting after the last grant
  always_comb begin
    any = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = 4'((int'(last_q) + k) % NCH);
      if (!any && elig[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst)
    if (!rst) st_q <= IDLE;
    else      st_q <= st_d;

  // FSM next state
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (any) st_d = RD;
      RD: begin
        if (abort)       st_d = IDLE;
        else if (ack_ok) st_d = WR;
      end
      WR: begin
        if (abort)       st_d = IDLE;
        else if (ack_ok) st_d = DONE;
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // FSM outputs: bus strobes and completion pulse
  always_comb begin
    m_cyc_o   = 1'b0;
    m_stb_o   = 1'b0;
    m_we_o    = 1'b0;
    m_adr_o   = '0;
    dma_ack_o = '0;
    unique case (st_q)
      RD: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_adr_o = sa_q;
      end
      WR: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_adr_o = da_q;
      end
      DONE: dma_ack_o[ch_q] = 1'b1;
      default: ;
    endcase
  end

  assign m_dat_o  = dat_q;
  assign busy_o   = (st_q != IDLE);
  assign err_o    = err_q;
  assign err_ch_o = errch_q;

  // transfer context, read data and ack timeout counter
  always_ff @(posedge clk_i or negedge rst)
    if (!rst) begin
      ch_q   <= '0;
      last_q <= 4'(NCH - 1);
      sa_q   <= '0;
      da_q   <= '0;
      dat_q  <= '0;
      to_q   <= '0;
    end else begin
      unique case (st_q)
        IDLE: if (any) begin
          ch_q   <= gnt;
          last_q <= gnt;
          sa_q   <= src_q[gnt];
          da_q   <= dst_q[gnt];
          to_q   <= '0;
        end
        RD: begin
          if (ack_ok) begin
            dat_q <= m_dat_i;
            to_q  <= '0;
          end else begin
            to_q  <= to_q + 8'd1;
          end
        end
        WR: to_q <= ack_ok ? 8'd0 : to_q + 8'd1;
        default: ;
      endcase
    end

  // sticky error flag; a new abort beats a clear
  always_ff @(posedge clk_i or negedge rst)
    if (!rst) begin
      err_q   <= 1'b0;
      errch_q <= '0;
    end else begin
      if (cfg_we_i && creg == 2'd3 && cfg_din_i[0]) begin
        err_q   <= 1'b0;
        errch_q <= '0;
      end
      if (abort) begin
        err_q   <= 1'b1;
        errch_q <= ch_q;
      end
    end

  // channel registers; DONE pointer update overrides a config write
  always_ff @(posedge clk_i or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        src_q[i]  <= '0;
        dst_q[i]  <= '0;
        ctrl_q[i] <= '0;
      end
    end else begin
      if (abort)
        ctrl_q[ch_q] <= ctrl_q[ch_q] & 3'b110;
      if (cfg_we_i && cok) begin
        unique case (creg)
          2'd0: src_q[cch]  <= cfg_din_i;
          2'd1: dst_q[cch]  <= cfg_din_i;
          2'd2: ctrl_q[cch] <= cfg_din_i[2:0];
          default: ;
        endcase
      end
      if (st_q == DONE) begin
        if (ctrl_q[ch_q][1]) src_q[ch_q] <= sa_q + 32'd4;
        if (ctrl_q[ch_q][2]) dst_q[ch_q] <= da_q + 32'd4;
      end
    end

  // config read mux
  always_comb begin
    cfg_dout_o = '0;
    if (creg == 2'd3)
      cfg_dout_o = {27'b0, errch_q, err_q};
    else if (cok) begin
      unique case (creg)
        2'd0: cfg_dout_o = src_q[cch];
        2'd1: cfg_dout_o = dst_q[cch];
        2'd2: cfg_dout_o = {29'b0, ctrl_q[cch]};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usbf_dma_eng.sv
// Randomized bench for usbf_dma_eng against a transfer-level
// model of pointers, arbitration and error status.
module tb_usbf_dma_eng;
  localparam int NCH = 16;

  logic           clk_i = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] dma_req_i = '0;
  logic [NCH-1:0] dma_ack_o;
  logic           cfg_we_i = 1'b0;
  logic [5:0]     cfg_adr_i = '0;
  logic [31:0]    cfg_din_i = '0;
  logic [31:0]    cfg_dout_o;
  logic [31:0]    m_adr_o, m_dat_o, m_dat_i;
  logic           m_we_o, m_stb_o, m_cyc_o, m_ack_i, m_err_i;
  logic           busy_o, err_o;
  logic [3:0]     err_ch_o;

  int checks = 0;
  int failures = 0;

  usbf_dma_eng #(.NCH(NCH), .TO_CYC(255)) dut (
    .clk_i(clk_i), .rst(rst),
    .dma_req_i(dma_req_i), .dma_ack_o(dma_ack_o),
    .cfg_we_i(cfg_we_i), .cfg_adr_i(cfg_adr_i),
    .cfg_din_i(cfg_din_i), .cfg_dout_o(cfg_dout_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .busy_o(busy_o), .err_o(err_o), .err_ch_o(err_ch_o)
  );

  always #5 clk_i = ~clk_i;

  // Wishbone slave: data = address ^ key, programmable wait states
  logic [31:0] key = '0;
  int  ws = 0;
  bit  hang = 1'b0;
  bit  werr = 1'b0;
  int  wcnt = 0;

  always @(posedge clk_i)
    if (m_stb_o && !m_ack_i) wcnt <= wcnt + 1;
    else                     wcnt <= 0;

  assign m_ack_i = m_cyc_o && m_stb_o && !hang && (wcnt >= ws);
  assign m_err_i = m_cyc_o && m_stb_o && m_we_o && werr;
  assign m_dat_i = m_adr_o ^ key;

  // monitors: completion pulses and completed bus writes
  logic [NCH-1:0] ack_q[$];
  logic [63:0]    wr_q[$];

  always @(negedge clk_i) begin
    if (dma_ack_o != '0) ack_q.push_back(dma_ack_o);
    if (m_cyc_o && m_stb_o && m_we_o && m_ack_i && !m_err_i)
      wr_q.push_back({m_adr_o, m_dat_o});
  end

  // reference model state
  logic [31:0] ms [NCH];
  logic [31:0] md [NCH];
  logic [2:0]  mc [NCH];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int rr_next(input int last, input logic [NCH-1:0] m);
    for (int k = 1; k <= NCH; k++)
      if (m[(last + k) % NCH]) return (last + k) % NCH;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      ms[i] = '0;
      md[i] = '0;
      mc[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst = 1'b0;
    dma_req_i = '0;
    cfg_we_i = 1'b0;
    hang = 1'b0;
    werr = 1'b0;
    ws = 0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst = 1'b1;
  endtask

  task automatic cfg_wr(input int ch, input int r, input logic [31:0] v);
    @(negedge clk_i);
    cfg_adr_i = {ch[3:0], r[1:0]};
    cfg_din_i = v;
    cfg_we_i = 1'b1;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    case (r)
      0: ms[ch] = v;
      1: md[ch] = v;
      2: mc[ch] = v[2:0];
      default: ;
    endcase
  endtask

  task automatic rb(input string tag, input int ch, input int r,
                    input logic [31:0] exp);
    cfg_adr_i = {ch[3:0], r[1:0]};
    #1;
    chk(tag, cfg_dout_o, exp);
  endtask

  // one request/ack exchange, optional DST write in the ack cycle
  task automatic run_xfer(input int ch, input int wsv, input bit dwr,
                          input logic [31:0] dv);
    logic [31:0] ea, ed, od;
    int lat;
    bit got;
    ea = md[ch];
    ed = ms[ch] ^ key;
    od = md[ch];
    ws = wsv;
    ack_q.delete();
    wr_q.delete();
    @(negedge clk_i);
    dma_req_i[ch] = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk_i);
      lat++;
      got = (dma_ack_o != '0);
    end
    dma_req_i[ch] = 1'b0;
    if (got && dwr) begin
      cfg_adr_i = {ch[3:0], 2'd1};
      cfg_din_i = dv;
      cfg_we_i = 1'b1;
    end
    chk("latency", 32'(lat), 32'(3 + 2 * wsv));
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    chk("ack_width", 32'(dma_ack_o), 32'd0);
    @(negedge clk_i);
    chk("idle_after", 32'(busy_o), 32'd0);
    chk("ack_ch", ack_q.size() == 1 ? 32'(ack_q[0]) : 32'hFFFF_FFFF,
        32'(1 << ch));
    chk("wr_adr", wr_q.size() == 1 ? wr_q[0][63:32] : ~ea, ea);
    chk("wr_dat", wr_q.size() == 1 ? wr_q[0][31:0] : ~ed, ed);
    if (dwr) md[ch] = dv;
    if (mc[ch][1]) ms[ch] = ms[ch] + 32'd4;
    if (mc[ch][2]) md[ch] = od + 32'd4;
    rb("src_ptr", ch, 0, ms[ch]);
    rb("dst_ptr", ch, 1, md[ch]);
  endtask

  // hold a request mask and compare the grant order
  task automatic rr_run(input logic [NCH-1:0] en, input logic [NCH-1:0] rq,
                        input int n);
    int g, w;
    do_reset();
    for (int i = 0; i < NCH; i++)
      if (en[i]) cfg_wr(i, 2, 32'd1);
    ack_q.delete();
    @(negedge clk_i);
    dma_req_i = rq;
    w = 0;
    while (ack_q.size() < n && w < 400) begin
      @(negedge clk_i);
      w++;
    end
    dma_req_i = '0;
    chk("rr_timeout", 32'(w < 400), 32'd1);
    g = NCH - 1;
    for (int i = 0; i < n; i++) begin
      g = rr_next(g, en & rq);
      chk("rr_grant", i < ack_q.size() ? 32'(ack_q[i]) : 32'd0,
          32'(1 << g));
    end
    w = 0;
    while (busy_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc_n, ch, wsv;
    bit dwr;
    logic [31:0] s, d, c;

    // reset state
    do_reset();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_errch", 32'(err_ch_o), 32'd0);
    chk("rst_cyc", 32'(m_cyc_o), 32'd0);
    chk("rst_stb", 32'(m_stb_o), 32'd0);
    chk("rst_we", 32'(m_we_o), 32'd0);
    chk("rst_adr", m_adr_o, 32'd0);
    chk("rst_dat", m_dat_o, 32'd0);
    chk("rst_ack", 32'(dma_ack_o), 32'd0);
    rb("rst_status", 0, 3, 32'd0);
    rb("rst_src3", 3, 0, 32'd0);
    rb("rst_ctrl9", 9, 2, 32'd0);

    // directed single word
    key = 32'h1000 ^ 32'hDEAD_BEEF;
    cfg_wr(0, 0, 32'h1000);
    cfg_wr(0, 1, 32'h2000);
    cfg_wr(0, 2, 32'h7);
    run_xfer(0, 0, 1'b0, 32'h0);

    // randomized single-channel transfers
    for (int it = 0; it < 24; it++) begin
      ch = $urandom_range(0, NCH - 1);
      s = (it % 5 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      d = (it % 7 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      c = $urandom | 32'd1;
      key = $urandom;
      wsv = $urandom_range(0, 3);
      dwr = ($urandom_range(0, 3) == 0);
      cfg_wr(ch, 0, s);
      cfg_wr(ch, 1, d);
      cfg_wr(ch, 2, c);
      rb("ctrl_mask", ch, 2, {29'b0, mc[ch]});
      run_xfer(ch, wsv, dwr, $urandom);
    end

    // address wrap and DONE-cycle DST write
    do_reset();
    cfg_wr(4, 0, 32'hFFFF_FFFC);
    cfg_wr(4, 1, 32'h300);
    cfg_wr(4, 2, 32'h3);
    run_xfer(4, 0, 1'b0, 32'h0);
    run_xfer(4, 1, 1'b1, 32'hABC0);
    cfg_wr(4, 2, 32'h7);
    run_xfer(4, 0, 1'b1, 32'h5550);

    // arbitration
    rr_run(16'h0024, 16'h0024, 4);
    rr_run(16'h0009, 16'h0009, 2);
    rr_run(16'hFFFF, 16'($urandom_range(1, 65535)), 6);

    // read timeout
    do_reset();
    cfg_wr(7, 0, 32'h4000);
    cfg_wr(7, 1, 32'h5000);
    cfg_wr(7, 2, 32'h7);
    hang = 1'b1;
    ack_q.delete();
    @(negedge clk_i);
    dma_req_i[7] = 1'b1;
    n = 0;
    cyc_n = 0;
    while (n < 600) begin
      @(negedge clk_i);
      n++;
      if (m_cyc_o) cyc_n++;
      else if (!busy_o) break;
    end
    chk("to_cycles", 32'(cyc_n), 32'd255);
    @(negedge clk_i);
    @(negedge clk_i);
    dma_req_i[7] = 1'b0;
    hang = 1'b0;
    chk("to_regrant", 32'(busy_o), 32'd0);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_errch", 32'(err_ch_o), 32'd7);
    chk("to_noack", 32'(ack_q.size()), 32'd0);
    rb("to_ctrl", 7, 2, 32'h6);
    rb("to_src", 7, 0, 32'h4000);
    rb("to_status", 2, 3, 32'hF);
    cfg_wr(0, 3, 32'h1);
    chk("clr_err", 32'(err_o), 32'd0);
    chk("clr_errch", 32'(err_ch_o), 32'd0);

    // bus error together with ack on the write
    do_reset();
    cfg_wr(9, 0, 32'h6000);
    cfg_wr(9, 1, 32'h7000);
    cfg_wr(9, 2, 32'h7);
    werr = 1'b1;
    ack_q.delete();
    wr_q.delete();
    @(negedge clk_i);
    dma_req_i[9] = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk_i);
      n++;
      if (!busy_o) break;
    end
    @(negedge clk_i);
    dma_req_i[9] = 1'b0;
    werr = 1'b0;
    chk("be_err", 32'(err_o), 32'd1);
    chk("be_errch", 32'(err_ch_o), 32'd9);
    chk("be_noack", 32'(ack_q.size()), 32'd0);
    chk("be_nowr", 32'(wr_q.size()), 32'd0);
    rb("be_dst", 9, 1, 32'h7000);
    rb("be_src", 9, 0, 32'h6000);
    rb("be_ctrl", 9, 2, 32'h6);

    // reset during a waited write
    do_reset();
    cfg_wr(1, 0, 32'h100);
    cfg_wr(1, 1, 32'h200);
    cfg_wr(1, 2, 32'h7);
    ws = 3;
    ack_q.delete();
    wr_q.delete();
    @(negedge clk_i);
    dma_req_i[1] = 1'b1;
    n = 0;
    while (!m_we_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    chk("ar_in_wr", 32'(m_we_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_cyc", 32'(m_cyc_o), 32'd0);
    chk("ar_stb", 32'(m_stb_o), 32'd0);
    chk("ar_ack", 32'(dma_ack_o), 32'd0);
    chk("ar_busy", 32'(busy_o), 32'd0);
    rb("ar_src", 1, 0, 32'd0);
    rb("ar_dst", 1, 1, 32'd0);
    rb("ar_ctrl", 1, 2, 32'd0);
    dma_req_i = '0;
    @(negedge clk_i);
    rst = 1'b1;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    chk("ar_noack", 32'(ack_q.size()), 32'd0);
    chk("ar_nowr", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
